hs_stream_src: RTL and testbench

- Valid/ready stream transmitter that sources beats into the upstream side of the handshake pipeline (valid, ready, data).
- A one-shot command (length, seed, mode, gap) makes it emit a deterministic burst of len beats, either incrementing or LFSR data, with optional idle gaps between beats.
- Obeys the pipeline's handshake contract, so a downstream skid-buffer chain can be stressed with known traffic and checked beat-for-beat.

---
 rtl/hs_stream_pkg.sv | 33 +++
 rtl/hs_lfsr_step.sv | 18 +
 rtl/hs_stream_src.sv | 159 +++++++++++++++
 tb/tb_hs_stream_src.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_stream_pkg
// Description : Shared types, constants and data-step helper for the stream
//               source and its matching sink/checker.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } hs_state_e;

    localparam logic        MODE_INC     = 1'b0;
    localparam logic        MODE_LFSR    = 1'b1;
    localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

    // Operates at 64 bits; callers zero-extend d/poly and keep the low WIDTH
    // bits of the result, which yields the mod-2^WIDTH wrap for free.
    function automatic logic [63:0] next_data(input logic        mode,
                                              input logic [63:0] d,
                                              input logic [63:0] poly);
        if (mode == MODE_LFSR) begin
            return (d >> 1) ^ (d[0] ? poly : 64'd0);
        end
        return d + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : hs_lfsr_step
// Description : One combinational step of a right-shifting Galois LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_lfsr_step #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h8020_0003)
) (
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    assign o_q = (i_d >> 1) ^ (i_d[0] ? POLY : '0);

endmodule
`default_nettype wire

// File: rtl/hs_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : hs_stream_src
// Description : Valid/ready burst source emitting incrementing or LFSR data
//               with optional idle gaps between beats.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_stream_src
    import hs_stream_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int          LEN_W = 16,
    parameter int          GAP_W = 4,
    parameter logic [31:0] POLY  = DEFAULT_POLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             mode_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] beat_cnt_o
);

    localparam logic [WIDTH-1:0] c_poly    = WIDTH'(POLY);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
    localparam logic [GAP_W-1:0] c_gap_one = GAP_W'(1);

    hs_state_e        r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic             r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_last, w_last_nxt;
    logic             w_xfer;
    logic [WIDTH-1:0] w_lfsr_q;
    logic [WIDTH-1:0] w_data_adv;

    hs_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (c_poly)
    ) u_lfsr_step (
        .i_d (r_data),
        .o_q (w_lfsr_q)
    );

    assign w_data_adv = (r_mode == MODE_LFSR) ? w_lfsr_q : (r_data + c_one);
    assign w_xfer     = r_valid && ready_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_cnt_nxt     = r_cnt;
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
        w_mode_nxt    = r_mode;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_len_nxt  = len_i;
                    w_mode_nxt = mode_i;
                    w_gap_nxt  = gap_i;
                    w_cnt_nxt  = '0;
                    if (len_i != '0) begin
                        // A zero seed would lock the LFSR at zero forever.
                        w_data_nxt  = (mode_i == MODE_LFSR && seed_i == '0) ? c_one : seed_i;
                        w_last_nxt  = (len_i == c_len_one);
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + c_len_one;
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_data_nxt = w_data_adv;
                        if (r_gap == '0) begin
                            w_last_nxt = (w_cnt_nxt == r_len - c_len_one);
                        end else begin
                            w_valid_nxt   = 1'b0;
                            w_gap_cnt_nxt = r_gap;
                            w_state_nxt   = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_one) begin
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_cnt == r_len - c_len_one);
                    w_state_nxt = ST_SEND;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_gap_one;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_mode    <= MODE_INC;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_len     <= w_len_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_mode    <= w_mode_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign valid_o    = r_valid;
    assign data_o     = r_data;
    assign last_o     = r_last;
    assign beat_cnt_o = r_cnt;
    assign done_o     = (r_state == ST_DONE);
    assign busy_o     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hs_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_stream_src
// Description : Directed scoreboard bench for hs_stream_src.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_stream_src;
    import hs_stream_pkg::*;

    localparam int WIDTH  = 32;
    localparam int LEN_W  = 16;
    localparam int GAP_W  = 4;
    localparam int BUDGET = 200;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic [WIDTH-1:0] seed_i;
    logic             mode_i;
    logic [GAP_W-1:0] gap_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             last_o;
    logic             busy_o;
    logic             done_o;
    logic [LEN_W-1:0] beat_cnt_o;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [32:0] exp_q[$];

    hs_stream_src #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .GAP_W (GAP_W),
        .POLY  (32'h8020_0003)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .len_i      (len_i),
        .seed_i     (seed_i),
        .mode_i     (mode_i),
        .gap_i      (gap_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .last_o     (last_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .beat_cnt_o (beat_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] seed,
                               input logic mode, input logic [GAP_W-1:0] gap);
        len_i   = len;
        seed_i  = seed;
        mode_i  = mode;
        gap_i   = gap;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done_o !== 1'b1 && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check("done_seen", done_o, 1);
    endtask

    // Pops the scoreboard on every handshake and checks hold-while-stalled.
    task automatic monitor();
        logic        prev_stall = 1'b0;
        logic [32:0] prev_beat  = '0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", valid_o, 1);
                check("hold_beat", {last_o, data_o}, prev_beat);
            end
            if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_beat: got data 0x%0h last %0b expected no beat", data_o, last_o);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", data_o, e[31:0]);
                    check("beat_last", last_o, e[32]);
                end
            end
            prev_stall = (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b0);
            prev_beat  = {last_o, data_o};
        end
    endtask

    initial begin
        int          cyc;
        logic [6:0]  pat;
        logic [31:0] d;

        fork
            monitor();
        join_none

        rst_n = 1'b0; start_i = 1'b0; len_i = '0; seed_i = '0;
        mode_i = 1'b0; gap_i = '0; ready_i = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", data_o, 0);
        check("rst_cnt", beat_cnt_o, 0);

        // Incrementing burst wrapping through zero, full rate.
        ready_i = 1'b1;
        exp_q.push_back({1'b0, 32'hFFFF_FFFE});
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        exp_q.push_back({1'b0, 32'h0000_0000});
        exp_q.push_back({1'b1, 32'h0000_0001});
        start_burst(4, 32'hFFFF_FFFE, MODE_INC, 0);
        check("t1_latency_valid", valid_o, 1);
        check("t1_first_data", data_o, 32'hFFFF_FFFE);
        check("t1_busy", busy_o, 1);
        wait_done(cyc);
        check("t1_done_cycles", cyc, 4);
        check("t1_cnt", beat_cnt_o, 4);
        check("t1_busy_in_done", busy_o, 1);
        check("t1_valid_in_done", valid_o, 0);
        tick();
        check("t1_done_pulse", done_o, 0);
        check("t1_busy_after", busy_o, 0);
        check("t1_cnt_hold", beat_cnt_o, 4);
        check("t1_queue_empty", exp_q.size(), 0);

        // Backpressure on the first beat.
        ready_i = 1'b0;
        exp_q.push_back({1'b0, 32'h10});
        exp_q.push_back({1'b0, 32'h11});
        exp_q.push_back({1'b1, 32'h12});
        start_burst(3, 32'h10, MODE_INC, 0);
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", valid_o, 1);
            check("t2_stall_data", data_o, 32'h10);
            tick();
        end
        ready_i = 1'b1;
        wait_done(cyc);
        check("t2_done_cycles", cyc, 3);
        check("t2_cnt", beat_cnt_o, 3);
        tick();
        check("t2_queue_empty", exp_q.size(), 0);

        // LFSR with two idle cycles between beats.
        exp_q.push_back({1'b0, 32'h0000_0001});
        exp_q.push_back({1'b0, 32'h8020_0003});
        exp_q.push_back({1'b1, 32'hC030_0002});
        start_burst(3, 32'h1, MODE_LFSR, 2);
        pat = 7'b1001001;
        for (int i = 0; i < 7; i++) begin
            check("t3_gap_valid", valid_o, pat[i]);
            if (i == 6) check("t3_last", last_o, 1);
            tick();
        end
        check("t3_done", done_o, 1);
        check("t3_cnt", beat_cnt_o, 3);
        tick();
        check("t3_queue_empty", exp_q.size(), 0);

        // Zero seed in LFSR mode is replaced by 1; single-beat burst.
        exp_q.push_back({1'b1, 32'h1});
        start_burst(1, 32'h0, MODE_LFSR, 0);
        check("t3b_seed_fix", data_o, 32'h1);
        check("t3b_last", last_o, 1);
        wait_done(cyc);
        check("t3b_done_cycles", cyc, 1);
        tick();

        // Zero-length burst.
        start_burst(0, 32'hAB, MODE_INC, 0);
        check("t4_zero_done", done_o, 1);
        check("t4_zero_valid", valid_o, 0);
        check("t4_zero_busy", busy_o, 1);
        check("t4_zero_cnt", beat_cnt_o, 0);
        tick();
        check("t4_zero_done_off", done_o, 0);
        check("t4_zero_busy_off", busy_o, 0);

        // Start pulses mid-burst and during DONE are ignored.
        exp_q.push_back({1'b0, 32'h100});
        exp_q.push_back({1'b0, 32'h101});
        exp_q.push_back({1'b0, 32'h102});
        exp_q.push_back({1'b1, 32'h103});
        start_burst(4, 32'h100, MODE_INC, 1);
        tick();
        len_i = 9;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(cyc);
        check("t4_ignore_cnt", beat_cnt_o, 4);
        len_i = 5;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t4_done_start_valid", valid_o, 0);
        check("t4_done_start_busy", busy_o, 0);
        tick();
        check("t4_queue_empty", exp_q.size(), 0);

        // Reset after two of eight beats, then a fresh full burst.
        exp_q.push_back({1'b0, 32'h200});
        exp_q.push_back({1'b0, 32'h201});
        start_burst(8, 32'h200, MODE_INC, 0);
        tick();
        tick();
        check("t5_cnt_before_rst", beat_cnt_o, 2);
        rst_n = 1'b0;
        tick();
        check("t5_rst_valid", valid_o, 0);
        check("t5_rst_done", done_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_cnt", beat_cnt_o, 0);
        check("t5_rst_data", data_o, 0);
        rst_n = 1'b1;
        tick();
        check("t5_no_done", done_o, 0);
        check("t5_partial_queue", exp_q.size(), 0);
        d = 32'h200;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({(i == 7), d});
            d = 32'(next_data(MODE_INC, {32'd0, d}, {32'd0, DEFAULT_POLY}));
        end
        start_burst(8, 32'h200, MODE_INC, 0);
        wait_done(cyc);
        check("t5_done_cycles", cyc, 8);
        check("t5_cnt", beat_cnt_o, 8);
        tick();
        check("t5_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
